synaptic_accumulator: RTL and testbench

Parametrised synaptic input stage for one neuron. It latches incoming spike source addresses against a per-synapse address/weight table during a timestep. At each timestep boundary it serially sums the IEEE-754 single-precision weights of every synapse that spiked, and presents the sum to the neuron's potential-update logic. Spike capture is double-buffered, so spikes for the next timestep are recorded while the previous timestep is being summed. It replaces the fixed 5-connection, unclocked accumulator with a clocked, resettable, table-loadable block.

---
 rtl/synaptic_accumulator.sv | 165 ++++++++++++++++
 tb/tb_synaptic_accumulator.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/synaptic_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | synaptic_accumulator: double-buffered spike capture and serial FP32 weight |
// | summation for one neuron.                           Revision: 1.0          |
// +----------------------------------------------------------------------------+
module synaptic_accumulator #(
  parameter int NUM_CONN = 5,
  parameter int ADDR_W   = 12,
  parameter int IDX_W    = (NUM_CONN > 1) ? $clog2(NUM_CONN) : 1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [31:0]       cfg_weight,
  input  logic              spike_valid,
  input  logic [ADDR_W-1:0] spike_addr,
  input  logic              timestep_end,
  output logic              out_valid,
  output logic [31:0]       out_sum,
  output logic              busy,
  output logic              spike_miss,
  output logic              ts_drop
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_DONE = 2'd2} state_t;

  state_t              r_state, w_state_next;
  logic [NUM_CONN-1:0] r_valid, r_pending, r_snap, w_match, w_cfg_sel;
  logic [ADDR_W-1:0]   r_addr [NUM_CONN];
  logic [31:0]         r_weight [NUM_CONN];
  logic [IDX_W-1:0]    r_idx;
  logic [31:0]         r_acc, w_acc_next, r_out_sum;
  logic                r_out_valid, r_spike_miss, r_ts_drop;
  logic                w_start, w_last, w_cfg_en;

  // Round-to-nearest-even FP32 add; denormals are flushed to zero.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [26:0] mx, my, sh;
    logic [27:0] s;
    logic [24:0] m25;
    logic        rnd;
    int          d, e;
    if (a[30:0] >= b[30:0]) begin x = a; y = b; end
    else begin x = b; y = a; end
    if (x[30:23] == 8'h00) return 32'h0;
    if (y[30:23] == 8'h00 || x[30:23] == 8'hFF) return x;
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    d  = int'(x[30:23]) - int'(y[30:23]);
    e  = int'(x[30:23]);
    if (d > 26) begin
      sh = 27'd1;
    end else begin
      sh    = my >> d;
      sh[0] = sh[0] | (|(my & ((27'd1 << d) - 27'd1)));
    end
    if (x[31] == y[31]) begin
      s = {1'b0, mx} + {1'b0, sh};
      if (s[27]) begin
        s = {1'b0, s[27:2], s[1] | s[0]};
        e = e + 1;
      end
    end else begin
      s = {1'b0, mx} - {1'b0, sh};
      if (s == '0) return 32'h0;
      for (int k = 0; k < 26; k++) begin
        if (!s[26]) begin
          s = s << 1;
          e = e - 1;
        end
      end
    end
    rnd = s[2] & (s[1] | s[0] | s[3]);
    m25 = {1'b0, s[26:3]} + 25'(rnd);
    if (m25[24]) begin
      m25 = m25 >> 1;
      e   = e + 1;
    end
    if (e >= 255) return {x[31], 8'hFF, 23'h0};
    if (e <= 0) return 32'h0;
    return {x[31], 8'(e), m25[22:0]};
  endfunction

  assign w_cfg_en = cfg_we && (r_state == S_IDLE);

  for (genvar g = 0; g < NUM_CONN; g++) begin : g_entry
    assign w_match[g]   = spike_valid && r_valid[g] && (r_addr[g] == spike_addr);
    assign w_cfg_sel[g] = w_cfg_en && (cfg_idx == IDX_W'(g));
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = timestep_end && (r_state == S_IDLE);
    w_last       = (r_idx == IDX_W'(NUM_CONN - 1));
    w_acc_next   = r_snap[r_idx] ? fp_add(r_acc, r_weight[r_idx]) : r_acc;
    case (r_state)
      S_IDLE:  if (timestep_end) w_state_next = S_SCAN;
      S_SCAN:  if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Table contents need no reset: the valid bits gate every use.
  always_ff @(posedge CLK) begin
    for (int k = 0; k < NUM_CONN; k++) begin
      if (w_cfg_sel[k]) begin
        r_addr[k]   <= cfg_addr;
        r_weight[k] <= cfg_weight;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_valid      <= '0;
      r_pending    <= '0;
      r_snap       <= '0;
      r_idx        <= '0;
      r_acc        <= '0;
      r_out_sum    <= '0;
      r_out_valid  <= 1'b0;
      r_spike_miss <= 1'b0;
      r_ts_drop    <= 1'b0;
    end else begin
      r_valid      <= r_valid | w_cfg_sel;
      r_spike_miss <= spike_valid && (w_match == '0);
      r_ts_drop    <= timestep_end && (r_state != S_IDLE);
      r_out_valid  <= 1'b0;
      // A spike coinciding with the boundary belongs to the new timestep.
      if (w_start) begin
        r_snap    <= r_pending;
        r_pending <= w_match;
        r_acc     <= '0;
        r_idx     <= '0;
      end else begin
        r_pending <= r_pending | w_match;
      end
      if (r_state == S_SCAN) begin
        r_acc <= w_acc_next;
        r_idx <= r_idx + IDX_W'(1);
        if (w_last) begin
          r_out_sum   <= w_acc_next;
          r_out_valid <= 1'b1;
        end
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_sum    = r_out_sum;
  assign busy       = (r_state != S_IDLE);
  assign spike_miss = r_spike_miss;
  assign ts_drop    = r_ts_drop;

endmodule
`default_nettype wire

// File: tb/tb_synaptic_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_synaptic_accumulator: directed bench for a 5-entry and a 16-entry DUT.  |
// |                                                     Revision: 1.0          |
// +----------------------------------------------------------------------------+
module tb_synaptic_accumulator;

  logic        clk;
  logic        rst_n;
  logic        cfg_we, spike_valid, timestep_end;
  logic [2:0]  cfg_idx;
  logic [11:0] cfg_addr, spike_addr;
  logic [31:0] cfg_weight;
  logic        out_valid, busy, spike_miss, ts_drop;
  logic [31:0] out_sum;

  logic        wd_cfg_we, wd_spike_valid, wd_timestep_end;
  logic [3:0]  wd_cfg_idx;
  logic [11:0] wd_cfg_addr, wd_spike_addr;
  logic [31:0] wd_cfg_weight;
  logic        wd_out_valid, wd_busy, wd_spike_miss, wd_ts_drop;
  logic [31:0] wd_out_sum;

  int checks = 0;
  int errors = 0;

  synaptic_accumulator #(.NUM_CONN(5), .ADDR_W(12)) dut (
    .CLK(clk), .RESET_N(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_weight(cfg_weight), .spike_valid(spike_valid),
    .spike_addr(spike_addr), .timestep_end(timestep_end), .out_valid(out_valid),
    .out_sum(out_sum), .busy(busy), .spike_miss(spike_miss), .ts_drop(ts_drop)
  );

  synaptic_accumulator #(.NUM_CONN(16), .ADDR_W(12)) dut_wide (
    .CLK(clk), .RESET_N(rst_n), .cfg_we(wd_cfg_we), .cfg_idx(wd_cfg_idx),
    .cfg_addr(wd_cfg_addr), .cfg_weight(wd_cfg_weight), .spike_valid(wd_spike_valid),
    .spike_addr(wd_spike_addr), .timestep_end(wd_timestep_end), .out_valid(wd_out_valid),
    .out_sum(wd_out_sum), .busy(wd_busy), .spike_miss(wd_spike_miss), .ts_drop(wd_ts_drop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic [11:0] a, input logic [31:0] w);
    cfg_we = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_weight = w;
    tick;
    cfg_we = 1'b0;
  endtask

  task automatic spike(input logic [11:0] a);
    spike_valid = 1'b1; spike_addr = a;
    tick;
    spike_valid = 1'b0;
  endtask

  // Observes 12 cycles starting the cycle after the boundary edge.
  task automatic wait_result(output logic [31:0] sum, output int lat, output int pulses,
                             output logic busy_after);
    sum = 32'hDEADBEEF; lat = -1; pulses = 0; busy_after = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      if (lat > 0 && c == lat + 1) busy_after = busy;
      if (out_valid) begin
        if (pulses == 0) begin
          sum = out_sum;
          lat = c;
        end
        pulses++;
      end
      tick;
    end
  endtask

  task automatic run_timestep(output logic [31:0] sum, output int lat, output int pulses);
    logic ba;
    timestep_end = 1'b1;
    tick;
    timestep_end = 1'b0;
    wait_result(sum, lat, pulses, ba);
  endtask

  task automatic test_reset;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_sum !== 32'h0) begin errors++; $display("FAIL reset_out_sum: got %h expected 00000000", out_sum); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (spike_miss !== 1'b0) begin errors++; $display("FAIL reset_spike_miss: got %b expected 0", spike_miss); end
    checks++; if (ts_drop !== 1'b0) begin errors++; $display("FAIL reset_ts_drop: got %b expected 0", ts_drop); end
  endtask

  task automatic load_table;
    cfg_write(3'd0, 12'h010, 32'h3F800000);
    cfg_write(3'd1, 12'h011, 32'h40000000);
    cfg_write(3'd2, 12'h012, 32'h3F000000);
    cfg_write(3'd3, 12'h013, 32'hBF800000);
    cfg_write(3'd4, 12'h014, 32'h40600000);
  endtask

  task automatic test_basic_sum;
    logic [31:0] sum; int lat, pulses; logic ba;
    spike(12'h010); spike(12'h011); spike(12'h014);
    timestep_end = 1'b1;
    tick;
    timestep_end = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_start: got %b expected 1", busy); end
    wait_result(sum, lat, pulses, ba);
    checks++; if (sum !== 32'h40D00000) begin errors++; $display("FAIL basic_sum: got %h expected 40D00000", sum); end
    checks++; if (lat !== 6) begin errors++; $display("FAIL basic_latency: got %0d expected 6", lat); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL basic_pulses: got %0d expected 1", pulses); end
    checks++; if (ba !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b expected 0", ba); end
  endtask

  task automatic test_duplicates_and_empty;
    logic [31:0] sum; int lat, pulses;
    spike(12'h012); spike(12'h012); spike(12'h012);
    run_timestep(sum, lat, pulses);
    checks++; if (sum !== 32'h3F000000) begin errors++; $display("FAIL dup_sum: got %h expected 3F000000", sum); end
    run_timestep(sum, lat, pulses);
    checks++; if (sum !== 32'h00000000) begin errors++; $display("FAIL empty_sum: got %h expected 00000000", sum); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL empty_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_miss;
    logic [31:0] sum; int lat, pulses;
    cfg_write(3'd7, 12'h020, 32'h40000000);
    spike(12'h0FF);
    checks++; if (spike_miss !== 1'b1) begin errors++; $display("FAIL miss_pulse: got %b expected 1", spike_miss); end
    tick;
    checks++; if (spike_miss !== 1'b0) begin errors++; $display("FAIL miss_single: got %b expected 0", spike_miss); end
    spike(12'h020);
    checks++; if (spike_miss !== 1'b1) begin errors++; $display("FAIL miss_bad_idx: got %b expected 1", spike_miss); end
    spike(12'h010);
    checks++; if (spike_miss !== 1'b0) begin errors++; $display("FAIL miss_hit: got %b expected 0", spike_miss); end
    run_timestep(sum, lat, pulses);
    checks++; if (sum !== 32'h3F800000) begin errors++; $display("FAIL miss_sum: got %h expected 3F800000", sum); end
  endtask

  task automatic test_same_cycle;
    logic [31:0] sum; int lat, pulses; logic ba;
    spike_valid = 1'b1; spike_addr = 12'h013; timestep_end = 1'b1;
    tick;
    spike_valid = 1'b0; timestep_end = 1'b0;
    wait_result(sum, lat, pulses, ba);
    checks++; if (sum !== 32'h00000000) begin errors++; $display("FAIL same_cycle_now: got %h expected 00000000", sum); end
    run_timestep(sum, lat, pulses);
    checks++; if (sum !== 32'hBF800000) begin errors++; $display("FAIL same_cycle_next: got %h expected BF800000", sum); end
  endtask

  task automatic test_scan_spikes;
    logic [31:0] sum; int lat, pulses; logic ba;
    spike(12'h010);
    timestep_end = 1'b1;
    tick;
    timestep_end = 1'b0;
    fork
      wait_result(sum, lat, pulses, ba);
      begin
        tick;
        spike_valid = 1'b1; spike_addr = 12'h014;
        tick;
        spike_valid = 1'b0;
      end
    join
    checks++; if (sum !== 32'h3F800000) begin errors++; $display("FAIL scan_spike_now: got %h expected 3F800000", sum); end
    run_timestep(sum, lat, pulses);
    checks++; if (sum !== 32'h40600000) begin errors++; $display("FAIL scan_spike_next: got %h expected 40600000", sum); end
  endtask

  task automatic test_ts_drop_cfg;
    logic [31:0] sum; int lat, pulses; logic ba;
    logic drop_hi, drop_lo;
    spike(12'h011);
    timestep_end = 1'b1;
    tick;
    timestep_end = 1'b0;
    fork
      wait_result(sum, lat, pulses, ba);
      begin
        tick;
        timestep_end = 1'b1; spike_valid = 1'b1; spike_addr = 12'h012;
        cfg_we = 1'b1; cfg_idx = 3'd0; cfg_addr = 12'h030; cfg_weight = 32'h40000000;
        tick;
        timestep_end = 1'b0; spike_valid = 1'b0; cfg_we = 1'b0;
        drop_hi = ts_drop;
        tick;
        drop_lo = ts_drop;
      end
    join
    checks++; if (drop_hi !== 1'b1) begin errors++; $display("FAIL ts_drop_pulse: got %b expected 1", drop_hi); end
    checks++; if (drop_lo !== 1'b0) begin errors++; $display("FAIL ts_drop_single: got %b expected 0", drop_lo); end
    checks++; if (sum !== 32'h40000000) begin errors++; $display("FAIL ts_drop_sum: got %h expected 40000000", sum); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL ts_drop_no_restart: got %0d pulses expected 1", pulses); end
    spike(12'h030);
    checks++; if (spike_miss !== 1'b1) begin errors++; $display("FAIL cfg_busy_ignored: got %b expected 1", spike_miss); end
    spike(12'h010);
    run_timestep(sum, lat, pulses);
    checks++; if (sum !== 32'h3FC00000) begin errors++; $display("FAIL pending_kept_sum: got %h expected 3FC00000", sum); end
  endtask

  task automatic test_reset_mid_scan;
    logic [31:0] sum; int lat, pulses; logic ba;
    spike(12'h014);
    timestep_end = 1'b1;
    tick;
    timestep_end = 1'b0;
    tick; tick;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    checks++; if (out_sum !== 32'h0) begin errors++; $display("FAIL rst_mid_out_sum: got %h expected 00000000", out_sum); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b expected 0", out_valid); end
    tick; tick;
    rst_n = 1'b1;
    wait_result(sum, lat, pulses, ba);
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_mid_no_valid: got %0d pulses expected 0", pulses); end
    spike(12'h010);
    checks++; if (spike_miss !== 1'b1) begin errors++; $display("FAIL rst_table_cleared: got %b expected 1", spike_miss); end
    run_timestep(sum, lat, pulses);
    checks++; if (sum !== 32'h0) begin errors++; $display("FAIL rst_sum_zero: got %h expected 00000000", sum); end
  endtask

  task automatic test_wide;
    logic [31:0] sum; int lat;
    for (int i = 0; i < 16; i++) begin
      wd_cfg_we = 1'b1; wd_cfg_idx = 4'(i);
      wd_cfg_addr = (i == 3 || i == 9) ? 12'h200 : 12'(12'h100 + i);
      wd_cfg_weight = (i == 3) ? 32'h3FC00000 : (i == 9) ? 32'h3E800000 : 32'h3F800000;
      tick;
    end
    wd_cfg_we = 1'b0;
    wd_spike_valid = 1'b1; wd_spike_addr = 12'h200; tick;
    wd_spike_addr = 12'h10F; tick;
    wd_spike_valid = 1'b0;
    wd_timestep_end = 1'b1; tick; wd_timestep_end = 1'b0;
    sum = 32'hDEADBEEF; lat = -1;
    for (int c = 1; c <= 24; c++) begin
      if (wd_out_valid && lat < 0) begin sum = wd_out_sum; lat = c; end
      tick;
    end
    checks++; if (sum !== 32'h40300000) begin errors++; $display("FAIL wide_sum: got %h expected 40300000", sum); end
    checks++; if (lat !== 17) begin errors++; $display("FAIL wide_latency: got %0d expected 17", lat); end
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_weight = '0;
    spike_valid = 1'b0; spike_addr = '0; timestep_end = 1'b0;
    wd_cfg_we = 1'b0; wd_cfg_idx = '0; wd_cfg_addr = '0; wd_cfg_weight = '0;
    wd_spike_valid = 1'b0; wd_spike_addr = '0; wd_timestep_end = 1'b0;
    repeat (3) tick;
    test_reset;
    rst_n = 1'b1;
    tick;
    load_table;
    test_basic_sum;
    test_duplicates_and_empty;
    test_miss;
    test_same_cycle;
    test_scan_spikes;
    test_ts_drop_cfg;
    test_reset_mid_scan;
    test_wide;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
